// File: rtl/ble_uart_bridge.sv
// Host-side UART bridge for a BLE radio module: TX FIFO + serializer, RX deserializer + FIFO,
// overcurrent fault gating of TX. Optional RTS/CTS flow control when BLE_UART_FLOWCTL_EN is defined.
module ble_uart_bridge #(
  parameter int CLK_HZ     = 48000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       ble_txd,
  input  logic       ble_rxd,
  input  logic       ocp_n,
  output logic       ocp_fault,
  output logic       frame_err,
  output logic       rx_overrun,
  output logic       tx_busy
`ifdef BLE_UART_FLOWCTL_EN
  ,
  input  logic       cts_n,
  output logic       rts_n
`endif
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] MID_LAST = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  // Input synchronizers; idle-high lines reset to 1 so no false edge follows reset.
  logic [1:0] rxd_ff, ocp_ff;
  logic       rxd_s, ocp_s;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_ff <= 2'b11;
      ocp_ff <= 2'b11;
    end else begin
      rxd_ff <= {rxd_ff[0], ble_rxd};
      ocp_ff <= {ocp_ff[0], ocp_n};
    end
  end
  assign rxd_s = rxd_ff[1];
  assign ocp_s = ocp_ff[1];

  // Fault status toggles once the synchronized flag disagrees with it for 4 clocks.
  logic [1:0] ocp_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocp_cnt   <= '0;
      ocp_fault <= 1'b0;
    end else if (ocp_s == ocp_fault) begin
      if (ocp_cnt == 2'd3) begin
        ocp_fault <= !ocp_fault;
        ocp_cnt   <= '0;
      end else begin
        ocp_cnt <= ocp_cnt + 2'd1;
      end
    end else begin
      ocp_cnt <= '0;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wr, tx_rd;
  logic        tx_full, tx_empty, tx_push, tx_pop, rdy_q, tx_go;

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
  assign tx_ready = rdy_q && !tx_full;
  assign tx_push  = tx_valid && tx_ready;

  // NOTE: FIFO storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
    end
  end

`ifdef BLE_UART_FLOWCTL_EN
  logic [1:0] cts_ff;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cts_ff <= 2'b11;
    else        cts_ff <= {cts_ff[0], cts_n};
  end
  assign tx_go = !tx_empty && !ocp_fault && !cts_ff[1];
`else
  assign tx_go = !tx_empty && !ocp_fault;
`endif

  // ---------------- TX serializer ----------------
  uart_state_e tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n, tx_bit_inc;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          txd_q, txd_n;

  assign tx_bit_inc = tx_bit + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_sh    <= tx_sh_n;
      txd_q    <= txd_n;
    end
  end

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    txd_n      = txd_q;
    tx_pop     = 1'b0;
    unique case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        txd_n    = 1'b1;
        if (tx_go) begin
          tx_pop     = 1'b1;
          tx_sh_n    = tx_mem[tx_rd[AW-1:0]];
          tx_state_n = START;
          txd_n      = 1'b0;
        end
      end
      START: if (tx_cnt == DIV_LAST) begin
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
        tx_state_n = DATA;
        txd_n      = tx_sh[0];
      end
      DATA: if (tx_cnt == DIV_LAST) begin
        tx_cnt_n = '0;
        if (tx_bit == 3'd7) begin
          tx_state_n = STOP;
          txd_n      = 1'b1;
        end else begin
          tx_bit_n = tx_bit_inc;
          txd_n    = tx_sh[tx_bit_inc];
        end
      end
      STOP: if (tx_cnt == DIV_LAST) begin
        tx_cnt_n   = '0;
        tx_state_n = IDLE;
      end
    endcase
  end

  assign ble_txd = txd_q;
  assign tx_busy = (tx_state != IDLE) || !tx_empty;

  // ---------------- RX deserializer ----------------
  uart_state_e rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic          rx_brk, rx_brk_n, rx_push_req, ferr_n, ovr_n;
  logic          rx_full, rx_empty, rx_pop, rx_wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rx_brk     <= 1'b0;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bit     <= rx_bit_n;
      rx_sh      <= rx_sh_n;
      rx_brk     <= rx_brk_n;
      frame_err  <= ferr_n;
      rx_overrun <= ovr_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt + 1'b1;
    rx_bit_n    = rx_bit;
    rx_sh_n     = rx_sh;
    rx_brk_n    = rx_brk;
    rx_push_req = 1'b0;
    ferr_n      = 1'b0;
    unique case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        if (!rxd_s) rx_state_n = START;
      end
      START: if (rx_cnt == MID_LAST) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rxd_s ? IDLE : DATA;
      end
      DATA: if (rx_cnt == DIV_LAST) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rxd_s, rx_sh[7:1]};
        if (rx_bit == 3'd7) rx_state_n = STOP;
        else                rx_bit_n   = rx_bit + 3'd1;
      end
      STOP: begin
        if (rx_brk) begin
          // Broken stop bit: hold until the line returns to idle.
          rx_cnt_n = '0;
          if (rxd_s) begin
            rx_brk_n   = 1'b0;
            rx_state_n = IDLE;
          end
        end else if (rx_cnt == DIV_LAST) begin
          rx_cnt_n = '0;
          if (rxd_s) begin
            rx_push_req = 1'b1;
            rx_state_n  = IDLE;
          end else begin
            ferr_n   = 1'b1;
            rx_brk_n = 1'b1;
          end
        end
      end
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wr, rx_rd;

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign rx_valid = !rx_empty;
  assign rx_data  = rx_empty ? 8'h00 : rx_mem[rx_rd[AW-1:0]];
  assign rx_pop   = rx_valid && rx_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign rx_wr_en = rx_push_req && (!rx_full || rx_pop);
  assign ovr_n    = rx_push_req && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (rx_wr_en) rx_mem[rx_wr[AW-1:0]] <= rx_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_wr_en) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)   rx_rd <= rx_rd + 1'b1;
    end
  end

`ifdef BLE_UART_FLOWCTL_EN
  localparam logic [AW:0] RTS_LIMIT = (AW + 1)'(FIFO_DEPTH - 2);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rts_n <= 1'b1;
    else        rts_n <= (rx_wr - rx_rd) > RTS_LIMIT;
  end
`endif

endmodule

// File: tb/tb_ble_uart_bridge.sv
// Scoreboard bench for ble_uart_bridge at DIV=10: TX bytes decoded off ble_txd and RX bytes
// popped from the FIFO are compared against queues filled when stimulus is driven.
module tb_ble_uart_bridge;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic       ble_txd, ble_rxd, ocp_n, ocp_fault, frame_err, rx_overrun, tx_busy;
`ifdef BLE_UART_FLOWCTL_EN
  logic       cts_n = 1'b0;
  logic       rts_n;
`endif

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int rst_cnt = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  ble_uart_bridge #(.CLK_HZ(1152000), .BAUD(115200), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .ble_txd(ble_txd), .ble_rxd(ble_rxd),
    .ocp_n(ocp_n), .ocp_fault(ocp_fault),
    .frame_err(frame_err), .rx_overrun(rx_overrun), .tx_busy(tx_busy)
`ifdef BLE_UART_FLOWCTL_EN
    , .cts_n(cts_n), .rts_n(rts_n)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err === 1'b1)  ferr_cnt++;
    if (rx_overrun === 1'b1) ovr_cnt++;
  end

  always @(negedge rst_n) rst_cnt++;

  // RX sink: each accepted pop is compared with the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      check("rx_expected", 32'(rx_exp.size() != 0), 32'd1);
      if (rx_exp.size() != 0) check("rx_byte", 32'(rx_data), 32'(rx_exp.pop_front()));
    end
  end

  // TX monitor: decodes ble_txd at mid-bit; frames cut by a reset are discarded.
  always begin
    int r0;
    logic s0, sp;
    logic [7:0] b;
    @(negedge ble_txd);
    r0 = rst_cnt;
    repeat (5) @(negedge clk);
    s0 = ble_txd;
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      b[i] = ble_txd;
    end
    repeat (10) @(negedge clk);
    sp = ble_txd;
    if (rst_cnt == r0) begin
      check("tx_start_bit", 32'(s0), 32'd0);
      check("tx_stop_bit", 32'(sp), 32'd1);
      check("tx_expected", 32'(tx_exp.size() != 0), 32'd1);
      if (tx_exp.size() != 0) check("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
    end
  end

  task automatic push_tx(input logic [7:0] b, input bit expect_out);
    check("tx_ready_for_push", 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    if (expect_out) tx_exp.push_back(b);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    ble_rxd = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ble_rxd = b[i];
      repeat (10) @(negedge clk);
    end
    ble_rxd = stop;
    repeat (10) @(negedge clk);
    ble_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0, o0;
    logic [7:0] pat, v;
    rst_n = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; ble_rxd = 1'b1; ocp_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ble_txd", 32'(ble_txd), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_ocp_fault", 32'(ocp_fault), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_rx_overrun", 32'(rx_overrun), 32'd0);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("tx_ready_after_reset", 32'(tx_ready), 32'd1);

    // TX 0xA5: exact waveform and tx_busy timing relative to the push edge.
    pat = 8'hA5;
    push_tx(pat, 1'b1);
    check("tx_idle_at_push", 32'(ble_txd), 32'd1);
    check("tx_busy_on_push", 32'(tx_busy), 32'd1);
    @(negedge clk);
    check("tx_start_fall", 32'(ble_txd), 32'd0);
    repeat (9) @(negedge clk);
    check("tx_start_last", 32'(ble_txd), 32'd0);
    @(negedge clk);
    check("tx_a5_bit0", 32'(ble_txd), 32'(pat[0]));
    for (int i = 1; i < 8; i++) begin
      repeat (10) @(negedge clk);
      check($sformatf("tx_a5_bit%0d", i), 32'(ble_txd), 32'(pat[i]));
    end
    repeat (10) @(negedge clk);
    check("tx_a5_stop", 32'(ble_txd), 32'd1);
    repeat (9) @(negedge clk);
    check("tx_busy_100", 32'(tx_busy), 32'd1);
    @(negedge clk);
    check("tx_busy_101", 32'(tx_busy), 32'd0);

    // RX good frame.
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx_exp.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    check("rx_valid_3c", 32'(rx_valid), 32'd1);
    check("rx_head_3c", 32'(rx_data), 32'h3C);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rx_empty_after_pop", 32'(rx_valid), 32'd0);
    check("rx_3c_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("rx_3c_no_ovr", 32'(ovr_cnt - o0), 32'd0);

    // Broken stop bit, then a clean frame.
    send_frame(8'h55, 1'b0);
    check("rx_ferr_once", 32'(ferr_cnt - f0), 32'd1);
    check("rx_ferr_no_data", 32'(rx_valid), 32'd0);
    rx_exp.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    check("rx_12_drained", 32'(rx_exp.size()), 32'd0);
    check("rx_12_ferr_still_one", 32'(ferr_cnt - f0), 32'd1);

    // Overrun: 17 frames into a 16-entry FIFO with no consumer.
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    for (int i = 0; i < 17; i++) begin
      v = 8'h80 + 8'(i);
      if (i < 16) rx_exp.push_back(v);
      send_frame(v, 1'b1);
    end
    check("rx_overrun_once", 32'(ovr_cnt - o0), 32'd1);
    check("rx_full_valid", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("rx_overrun_drained", 32'(rx_exp.size()), 32'd0);
    check("rx_overrun_empty", 32'(rx_valid), 32'd0);

    // Overcurrent mid-frame: current frame completes, queued byte waits for the fault to clear.
    push_tx(8'hFF, 1'b1);
    push_tx(8'h01, 1'b1);
    repeat (40) @(negedge clk);
    ocp_n = 1'b0;
    repeat (5) @(negedge clk);
    check("ocp_fault_5clk", 32'(ocp_fault), 32'd0);
    @(negedge clk);
    check("ocp_fault_6clk", 32'(ocp_fault), 32'd1);
    repeat (70) @(negedge clk);
    check("tx_held_line", 32'(ble_txd), 32'd1);
    check("tx_held_busy", 32'(tx_busy), 32'd1);
    check("tx_ff_done", 32'(tx_exp.size()), 32'd1);
    ocp_n = 1'b1;
    repeat (6) @(negedge clk);
    check("ocp_clear_6clk", 32'(ocp_fault), 32'd0);
    check("tx_still_idle", 32'(ble_txd), 32'd1);
    @(negedge clk);
    check("tx_resume", 32'(ble_txd), 32'd0);
    repeat (110) @(negedge clk);
    check("tx_drained", 32'(tx_exp.size()), 32'd0);
    check("tx_idle_after_drain", 32'(tx_busy), 32'd0);

    // Reset in the middle of a TX data bit, with bytes held in both FIFOs.
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1);
    check("rx_held_before_reset", 32'(rx_valid), 32'd1);
    push_tx(8'h00, 1'b0);
    push_tx(8'hF0, 1'b0);
    push_tx(8'h33, 1'b0);
    repeat (20) @(negedge clk);
    check("tx_data_bit_low", 32'(ble_txd), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("tx_async_reset", 32'(ble_txd), 32'd1);
    check("rst_mid_busy", 32'(tx_busy), 32'd0);
    check("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("post_rst_tx_empty", 32'(tx_busy), 32'd0);
    check("post_rst_rx_empty", 32'(rx_valid), 32'd0);
    repeat (120) @(negedge clk);
    check("post_rst_line_quiet", 32'(ble_txd), 32'd1);
    check("post_rst_still_idle", 32'(tx_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
